// File: rtl/lab1_led_sequencer.sv
// Lab 1 LED sequencer: drives switch-decoded LEDs plus a free-running blink LED
// in LIVE mode, and on request walks a fixed pattern across all three LEDs as a
// timed self-test before returning to LIVE.
module lab1_led_sequencer #(
  parameter int BLINK_HALF_PERIOD = 10_000_000,
  parameter int STEP_CYCLES       = 24_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s,
  input  logic       test_req,
  output logic [2:0] led,
  output logic       test_busy,
  output logic       test_done
);

  localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX   = 3'd4;

  typedef enum logic {
    LIVE = 1'b0,
    TEST = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic [2:0]    step_idx, step_idx_next;
  logic [SW-1:0] step_cnt, step_cnt_next;
  logic [2:0]    led_next;
  logic          busy_next;
  logic          done_next;
  logic [2:0]    live_led;

  // Self-test pattern shown for each step index; out-of-range indices are dark.
  function automatic logic [2:0] test_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    test_pattern = 3'b001;
      3'd1:    test_pattern = 3'b010;
      3'd2:    test_pattern = 3'b100;
      3'd3:    test_pattern = 3'b111;
      default: test_pattern = 3'b000;
    endcase
  endfunction

  // Blink uses the pre-edge value, so LEDs follow the switches one cycle later.
  assign live_led = {blink, s[3] & s[2], s[1] ^ s[0]};

  // Free-running blink divider; keeps counting through self-tests.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LIVE;
      step_idx  <= '0;
      step_cnt  <= '0;
      led       <= 3'b000;
      test_busy <= 1'b0;
      test_done <= 1'b0;
    end else begin
      state     <= state_next;
      step_idx  <= step_idx_next;
      step_cnt  <= step_cnt_next;
      led       <= led_next;
      test_busy <= busy_next;
      test_done <= done_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next    = state;
    step_idx_next = step_idx;
    step_cnt_next = step_cnt;
    led_next      = led;
    busy_next     = test_busy;
    done_next     = 1'b0;
    case (state)
      LIVE: begin
        if (test_req) begin
          // Starting a test replaces this edge's live update with the first pattern.
          state_next    = TEST;
          step_idx_next = '0;
          step_cnt_next = '0;
          led_next      = test_pattern(3'd0);
          busy_next     = 1'b1;
        end else begin
          led_next  = live_led;
          busy_next = 1'b0;
        end
      end
      TEST: begin
        busy_next = 1'b1;
        if (step_cnt == STEP_LAST) begin
          step_cnt_next = '0;
          if (step_idx == LAST_IDX) begin
            // Last pattern done: back to LIVE with a one-cycle completion pulse.
            state_next    = LIVE;
            step_idx_next = '0;
            led_next      = live_led;
            busy_next     = 1'b0;
            done_next     = 1'b1;
          end else begin
            step_idx_next = step_idx + 1'b1;
            led_next      = test_pattern(step_idx + 1'b1);
          end
        end else begin
          step_cnt_next = step_cnt + 1'b1;
        end
      end
      default: begin
        state_next = LIVE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lab1_led_sequencer.sv
// Testbench for lab1_led_sequencer with small blink/step periods.
module tb_lab1_led_sequencer;

  localparam int BHP = 8;
  localparam int SC  = 4;

  logic       clk;
  logic       reset;
  logic [3:0] s;
  logic       test_req;
  logic [2:0] led;
  logic       test_busy;
  logic       test_done;

  int errors = 0;
  int checks = 0;

  // Reference model: blink derived from edges since reset, test from elapsed cycles.
  int         m_ticks;
  int         m_pos;
  logic [2:0] m_led;
  logic       m_busy;
  logic       m_done;
  logic [2:0] pat [5];

  lab1_led_sequencer #(.BLINK_HALF_PERIOD(BHP), .STEP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .s(s), .test_req(test_req),
    .led(led), .test_busy(test_busy), .test_done(test_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] sv, input logic tr);
    logic b;
    logic [2:0] live;
    if (r) begin
      m_ticks = 0; m_pos = -1;
      m_led = 3'b000; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      b = ((m_ticks / BHP) % 2) == 1;
      m_ticks++;
      live = {b, sv[3] & sv[2], sv[1] ^ sv[0]};
      m_done = 1'b0;
      if (m_pos < 0) begin
        if (tr) begin
          m_pos = 0; m_led = pat[0]; m_busy = 1'b1;
        end else begin
          m_led = live; m_busy = 1'b0;
        end
      end else begin
        m_pos++;
        if (m_pos == 5 * SC) begin
          m_pos = -1; m_led = live; m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_led = pat[m_pos / SC]; m_busy = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the falling edge.
  task automatic tick(input logic r, input logic [3:0] sv, input logic tr);
    reset = r; s = sv; test_req = tr;
    @(posedge clk);
    model_step(r, sv, tr);
    @(negedge clk);
    chk("led", 32'(led), 32'(m_led));
    chk("test_busy", 32'(test_busy), 32'(m_busy));
    chk("test_done", 32'(test_done), 32'(m_done));
  endtask

  typedef struct {
    logic [3:0] sv;
    logic [1:0] exp_lo;
  } live_vec_t;

  live_vec_t lv [4];

  initial begin
    int busy_cnt, done_cnt, low_cnt;
    bit seen;
    pat[0] = 3'b001; pat[1] = 3'b010; pat[2] = 3'b100; pat[3] = 3'b111; pat[4] = 3'b000;
    lv[0] = '{4'b1101, 2'b11};
    lv[1] = '{4'b0001, 2'b01};
    lv[2] = '{4'b0011, 2'b00};
    lv[3] = '{4'b1100, 2'b10};
    m_ticks = 0; m_pos = -1; m_led = '0; m_busy = 0; m_done = 0;
    reset = 1'b1; s = 4'b0000; test_req = 1'b1;
    @(negedge clk);

    // Reset held with test_req high: no test may start.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'b0000, 1'b1);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_busy", 32'(test_busy), 32'd0);
      chk("rst_done", 32'(test_done), 32'd0);
    end

    // Blink sequence from reset release, plus the live decode table.
    for (int i = 0; i < 24; i++) tick(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, lv[i].sv, 1'b0);
      chk("live_lo", 32'(led[1:0]), 32'(lv[i].exp_lo));
    end

    // Single test_req pulse: 20 busy cycles then one done pulse.
    tick(1'b0, 4'b1101, 1'b1);
    busy_cnt = int'(test_busy);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1'b0, 4'b1101, 1'b0);
      busy_cnt += int'(test_busy);
      if (test_done) seen = 1;
    end
    chk("pulse_busy_cycles", 32'(busy_cnt), 32'd20);
    chk("pulse_done_seen", 32'(seen), 32'd1);
    chk("done_led_lo", 32'(led[1:0]), 32'b11);
    tick(1'b0, 4'b1101, 1'b0);
    chk("done_once", 32'(test_done), 32'd0);

    // test_req held high: back-to-back tests with a one-cycle gap.
    low_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 4'b0110, 1'b1);
      if (!test_busy) low_cnt++;
      if (test_done) done_cnt++;
    end
    chk("held_low_cycles", 32'(low_cnt), 32'd2);
    chk("held_done_count", 32'(done_cnt), 32'd2);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'b0110, 1'b0);

    // Reset during pattern 111 aborts without a done pulse.
    tick(1'b0, 4'b1111, 1'b1);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1'b0, 4'b1111, 1'b0);
      if (led == 3'b111) seen = 1;
    end
    chk("reach_111", 32'(seen), 32'd1);
    tick(1'b1, 4'b1111, 1'b0);
    chk("abort_led", 32'(led), 32'd0);
    chk("abort_busy", 32'(test_busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 4'b1111, 1'b0);
      done_cnt += int'(test_done);
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_live_lo", 32'(led[1:0]), 32'b10);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 99) < 2), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
